// File: rtl/reg_file_sb.sv
// reg_file_sb: parametrised register file with two registered read ports,
// one write port, same-cycle write-to-read bypass and a per-register
// pending-write scoreboard.
//
// Read ports feed the operand stage, the write port is driven by writeback
// and the issue port marks destination registers busy until writeback.
// Every output comes straight from a flop; no combinational input-to-output
// paths exist.

module reg_file_sb #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 2,
  parameter int ZERO_REG = 0,
  localparam int DEPTH   = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] raddr0,
  input  logic              ren0,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic              ren1,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wren,
  input  logic [ADDR_W-1:0] iss_addr,
  input  logic              iss_en,
  output logic [DATA_W-1:0] rdata0,
  output logic              busy0,
  output logic [DATA_W-1:0] rdata1,
  output logic              busy1,
  output logic [DEPTH-1:0]  pending
);

  localparam int NPORT = 2;

  // Register 0 hard-wired to zero when ZERO_REG is set.
  logic zero_en;
  assign zero_en = (ZERO_REG != 0);

  // Writes and issues that actually take effect (register 0 filtered out
  // when it is hard-wired).
  logic wr_ok;
  logic iss_ok;
  assign wr_ok  = wren   && !(zero_en && (waddr    == '0));
  assign iss_ok = iss_en && !(zero_en && (iss_addr == '0));

  // Register array, scoreboard and registered read outputs.
  logic [DATA_W-1:0] regs_q    [DEPTH];
  logic [DATA_W-1:0] regs_d    [DEPTH];
  logic [DEPTH-1:0]  pending_q;
  logic [DEPTH-1:0]  pending_d;
  logic [DATA_W-1:0] rdata_q   [NPORT];
  logic [DATA_W-1:0] rdata_d   [NPORT];
  logic              busy_q    [NPORT];
  logic              busy_d    [NPORT];

  // Port-indexed views of the read request inputs.
  logic [ADDR_W-1:0] raddr_a   [NPORT];
  logic              ren_a     [NPORT];
  assign raddr_a[0] = raddr0;
  assign raddr_a[1] = raddr1;
  assign ren_a[0]   = ren0;
  assign ren_a[1]   = ren1;

  // Per-port hit flags against the writeback and issue ports.
  logic              wr_hit    [NPORT];
  logic              iss_hit   [NPORT];
  logic              zero_hit  [NPORT];

  // Address compares for each read port.
  always_comb begin
    for (int p = 0; p < NPORT; p++) begin
      wr_hit[p]   = wren   && (waddr    == raddr_a[p]);
      iss_hit[p]  = iss_en && (iss_addr == raddr_a[p]);
      zero_hit[p] = zero_en && (raddr_a[p] == '0);
    end
  end

  // Array next state: a single write per cycle.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (wr_ok) begin
      regs_d[waddr] = wdata;
    end
  end

  // Scoreboard next state: issue takes priority over a completing write so
  // a newer producer is never lost when the older one writes back.
  always_comb begin
    pending_d = pending_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (iss_ok && (iss_addr == ADDR_W'(i))) begin
        pending_d[i] = 1'b1;
      end else if (wren && (waddr == ADDR_W'(i))) begin
        pending_d[i] = 1'b0;
      end
    end
    if (zero_en) begin
      pending_d[0] = 1'b0;
    end
  end

  // Read port next state: bypass from writeback, busy from the scoreboard
  // adjusted for this cycle's write and issue; hold when not enabled.
  always_comb begin
    for (int p = 0; p < NPORT; p++) begin
      rdata_d[p] = rdata_q[p];
      busy_d[p]  = busy_q[p];
      if (ren_a[p]) begin
        if (zero_hit[p]) begin
          rdata_d[p] = '0;
          busy_d[p]  = 1'b0;
        end else begin
          rdata_d[p] = wr_hit[p] ? wdata : regs_q[raddr_a[p]];
          busy_d[p]  = (pending_q[raddr_a[p]] && !wr_hit[p]) || iss_hit[p];
        end
      end
    end
  end

  // State registers; reset clears everything and drops in-flight traffic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      pending_q <= '0;
      for (int p = 0; p < NPORT; p++) begin
        rdata_q[p] <= '0;
        busy_q[p]  <= 1'b0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
      pending_q <= pending_d;
      for (int p = 0; p < NPORT; p++) begin
        rdata_q[p] <= rdata_d[p];
        busy_q[p]  <= busy_d[p];
      end
    end
  end

  assign rdata0  = rdata_q[0];
  assign busy0   = busy_q[0];
  assign rdata1  = rdata_q[1];
  assign busy1   = busy_q[1];
  assign pending = pending_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed table vectors plus randomized traffic checked
// against a behavioural model, on a default instance and a ZERO_REG=1 one.

module tb_reg_file_sb;

  logic       clk;
  logic       rst_n;
  logic [1:0] raddr0, raddr1, waddr, iss_addr;
  logic       ren0, ren1, wren, iss_en;
  logic [7:0] wdata;

  logic [7:0] rdata0_a, rdata1_a, rdata0_z, rdata1_z;
  logic       busy0_a, busy1_a, busy0_z, busy1_z;
  logic [3:0] pending_a, pending_z;

  int n_pass = 0;
  int n_tot  = 0;

  reg_file_sb #(.DATA_W(8), .ADDR_W(2), .ZERO_REG(0)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .raddr0(raddr0), .ren0(ren0), .raddr1(raddr1), .ren1(ren1),
    .waddr(waddr), .wdata(wdata), .wren(wren),
    .iss_addr(iss_addr), .iss_en(iss_en),
    .rdata0(rdata0_a), .busy0(busy0_a), .rdata1(rdata1_a), .busy1(busy1_a),
    .pending(pending_a)
  );

  reg_file_sb #(.DATA_W(8), .ADDR_W(2), .ZERO_REG(1)) u_dz (
    .clk(clk), .rst_n(rst_n),
    .raddr0(raddr0), .ren0(ren0), .raddr1(raddr1), .ren1(ren1),
    .waddr(waddr), .wdata(wdata), .wren(wren),
    .iss_addr(iss_addr), .iss_en(iss_en),
    .rdata0(rdata0_z), .busy0(busy0_z), .rdata1(rdata1_z), .busy1(busy1_z),
    .pending(pending_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model (index 0: default, 1: ZERO_REG) -------
  logic [7:0] m_mem  [2][4];
  bit         m_pend [2][4];
  logic [7:0] m_rd   [2][2];
  bit         m_busy [2][2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) begin
        m_mem[k][i]  = 8'h00;
        m_pend[k][i] = 1'b0;
      end
      for (int p = 0; p < 2; p++) begin
        m_rd[k][p]   = 8'h00;
        m_busy[k][p] = 1'b0;
      end
    end
  endtask

  // One clock edge: reads see the pre-edge state plus this cycle's write and
  // issue; then the write lands and the scoreboard applies write then issue,
  // so an issue to the same register ends up winning.
  task automatic model_step();
    int ra [2];
    bit re [2];
    int wa, ia;
    ra[0] = int'(raddr0); ra[1] = int'(raddr1);
    re[0] = ren0;         re[1] = ren1;
    wa = int'(waddr);     ia = int'(iss_addr);
    for (int k = 0; k < 2; k++) begin
      for (int p = 0; p < 2; p++) begin
        if (re[p]) begin
          if (k == 1 && ra[p] == 0) begin
            m_rd[k][p]   = 8'h00;
            m_busy[k][p] = 1'b0;
          end else begin
            m_rd[k][p]   = (wren && wa == ra[p]) ? wdata : m_mem[k][ra[p]];
            m_busy[k][p] = (m_pend[k][ra[p]] && !(wren && wa == ra[p]))
                           || (iss_en && ia == ra[p]);
          end
        end
      end
      if (wren && !(k == 1 && wa == 0)) m_mem[k][wa] = wdata;
      if (wren) m_pend[k][wa] = 1'b0;
      if (iss_en && !(k == 1 && ia == 0)) m_pend[k][ia] = 1'b1;
    end
  endtask

  function automatic logic [3:0] model_pend(int k);
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = m_pend[k][i];
    return v;
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic idle();
    ren0 = 0; ren1 = 0; wren = 0; iss_en = 0;
    raddr0 = 0; raddr1 = 0; waddr = 0; iss_addr = 0; wdata = 0;
  endtask

  task automatic rand_in();
    ren0 = ($urandom_range(9) < 7); ren1 = ($urandom_range(9) < 7);
    wren = ($urandom_range(9) < 6); iss_en = ($urandom_range(9) < 4);
    raddr0 = 2'($urandom_range(3)); raddr1 = 2'($urandom_range(3));
    waddr = 2'($urandom_range(3)); iss_addr = 2'($urandom_range(3));
    wdata = 8'($urandom_range(255));
  endtask

  // Advance one edge and sample 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
  endtask

  task automatic chk_zero_outputs(string tag);
    chk({tag, " rdata0_a"}, 32'(rdata0_a), 0);
    chk({tag, " busy0_a"},  32'(busy0_a), 0);
    chk({tag, " rdata1_a"}, 32'(rdata1_a), 0);
    chk({tag, " busy1_a"},  32'(busy1_a), 0);
    chk({tag, " pending_a"}, 32'(pending_a), 0);
    chk({tag, " rdata0_z"}, 32'(rdata0_z), 0);
    chk({tag, " rdata1_z"}, 32'(rdata1_z), 0);
    chk({tag, " pending_z"}, 32'(pending_z), 0);
  endtask

  // ---------------- directed vectors (default instance) ----------------
  typedef struct {
    logic       ren0;  logic [1:0] ra0;
    logic       ren1;  logic [1:0] ra1;
    logic       wren;  logic [1:0] wa;  logic [7:0] wd;
    logic       iss;   logic [1:0] ia;
    logic [7:0] e_rd0; logic       e_b0;
    logic [7:0] e_rd1; logic       e_b1;
    logic [3:0] e_pend;
  } vec_t;

  vec_t vecs [10];

  initial begin
    // ren0 ra0 ren1 ra1 wren wa wd iss ia | rd0 b0 rd1 b1 pend
    vecs[0] = '{0, 0, 0, 0, 1, 2, 8'hA5, 0, 0, 8'h00, 0, 8'h00, 0, 4'b0000};
    vecs[1] = '{1, 2, 0, 0, 0, 0, 8'h00, 0, 0, 8'hA5, 0, 8'h00, 0, 4'b0000};
    vecs[2] = '{1, 3, 1, 3, 1, 3, 8'h3C, 0, 0, 8'h3C, 0, 8'h3C, 0, 4'b0000};
    vecs[3] = '{0, 0, 0, 0, 0, 0, 8'h00, 1, 1, 8'h3C, 0, 8'h3C, 0, 4'b0010};
    vecs[4] = '{1, 1, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 1, 8'h3C, 0, 4'b0010};
    vecs[5] = '{0, 0, 1, 1, 1, 1, 8'h11, 0, 0, 8'h00, 1, 8'h11, 0, 4'b0000};
    vecs[6] = '{1, 1, 1, 1, 1, 1, 8'h22, 1, 1, 8'h22, 1, 8'h22, 1, 4'b0010};
    vecs[7] = '{1, 2, 0, 0, 0, 0, 8'h00, 1, 1, 8'hA5, 0, 8'h22, 1, 4'b0010};
    vecs[8] = '{1, 0, 0, 0, 1, 0, 8'h77, 1, 0, 8'h77, 1, 8'h22, 1, 4'b0011};
    vecs[9] = '{0, 0, 1, 0, 1, 0, 8'h88, 0, 0, 8'h77, 1, 8'h88, 0, 4'b0010};
  end

  // ---------------- main sequence ----------------
  initial begin
    idle();
    rst_n = 1'b0;

    // Reset held with random inputs: everything stays 0.
    repeat (4) begin
      rand_in();
      @(posedge clk);
      #1;
    end
    chk_zero_outputs("reset_hold");
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Every address reads 0 / not busy after reset.
    for (int a = 0; a < 4; a++) begin
      ren0 = 1; ren1 = 1; raddr0 = 2'(a); raddr1 = 2'(a);
      tick();
      chk("post_reset rdata0", 32'(rdata0_a), 0);
      chk("post_reset busy0",  32'(busy0_a), 0);
      chk("post_reset rdata1", 32'(rdata1_a), 0);
      chk("post_reset busy1",  32'(busy1_a), 0);
    end
    idle();

    // Table vectors.
    for (int v = 0; v < 10; v++) begin
      ren0 = vecs[v].ren0; raddr0 = vecs[v].ra0;
      ren1 = vecs[v].ren1; raddr1 = vecs[v].ra1;
      wren = vecs[v].wren; waddr = vecs[v].wa; wdata = vecs[v].wd;
      iss_en = vecs[v].iss; iss_addr = vecs[v].ia;
      tick();
      chk($sformatf("vec%0d rdata0", v), 32'(rdata0_a), 32'(vecs[v].e_rd0));
      chk($sformatf("vec%0d busy0", v),  32'(busy0_a),  32'(vecs[v].e_b0));
      chk($sformatf("vec%0d rdata1", v), 32'(rdata1_a), 32'(vecs[v].e_rd1));
      chk($sformatf("vec%0d busy1", v),  32'(busy1_a),  32'(vecs[v].e_b1));
      chk($sformatf("vec%0d pending", v), 32'(pending_a), 32'(vecs[v].e_pend));
    end
    idle();

    // Hold: read reg 2, then keep ren0 low while reg 2 changes.
    ren0 = 1; raddr0 = 2;
    tick();
    chk("hold_setup rdata0", 32'(rdata0_a), 32'h A5);
    ren0 = 0;
    for (int c = 0; c < 3; c++) begin
      wren = 1; waddr = 2; wdata = 8'(c + 1);
      iss_en = (c == 1); iss_addr = 2;
      tick();
      chk($sformatf("hold%0d rdata0", c), 32'(rdata0_a), 32'h A5);
      chk($sformatf("hold%0d busy0", c),  32'(busy0_a), 0);
    end
    idle();
    ren0 = 1; raddr0 = 2;
    tick();
    chk("hold_after rdata0", 32'(rdata0_a), 32'h03);
    chk("hold_after busy0",  32'(busy0_a), 0);
    idle();

    // Zero register instance: write 0xFF and issue to reg 0 with same-cycle reads.
    wren = 1; waddr = 0; wdata = 8'hFF; iss_en = 1; iss_addr = 0;
    ren0 = 1; raddr0 = 0; ren1 = 1; raddr1 = 0;
    tick();
    chk("zero_same rdata0", 32'(rdata0_z), 0);
    chk("zero_same busy0",  32'(busy0_z), 0);
    chk("zero_same rdata1", 32'(rdata1_z), 0);
    chk("zero_same busy1",  32'(busy1_z), 0);
    chk("zero_same pend0",  32'(pending_z[0]), 0);
    wren = 0; iss_en = 0;
    tick();
    chk("zero_next rdata0", 32'(rdata0_z), 0);
    chk("zero_next busy0",  32'(busy0_z), 0);
    chk("zero_next pend0",  32'(pending_z[0]), 0);
    idle();

    // Randomized traffic against the model, with one mid-run async reset.
    rst_n = 1'b0;
    #2;
    model_reset();
    rst_n = 1'b1;
    for (int c = 0; c < 600; c++) begin
      rand_in();
      if (c == 300) begin
        rst_n = 1'b0;
        #1;
        model_reset();
        chk_zero_outputs("mid_reset");
        tick();
        rst_n = 1'b1;
        rand_in();
      end
      tick();
      chk("rand rdata0_a", 32'(rdata0_a), 32'(m_rd[0][0]));
      chk("rand busy0_a",  32'(busy0_a),  32'(m_busy[0][0]));
      chk("rand rdata1_a", 32'(rdata1_a), 32'(m_rd[0][1]));
      chk("rand busy1_a",  32'(busy1_a),  32'(m_busy[0][1]));
      chk("rand pending_a", 32'(pending_a), 32'(model_pend(0)));
      chk("rand rdata0_z", 32'(rdata0_z), 32'(m_rd[1][0]));
      chk("rand busy0_z",  32'(busy0_z),  32'(m_busy[1][0]));
      chk("rand rdata1_z", 32'(rdata1_z), 32'(m_rd[1][1]));
      chk("rand busy1_z",  32'(busy1_z),  32'(m_busy[1][1]));
      chk("rand pending_z", 32'(pending_z), 32'(model_pend(1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
